data_mem_responder: RTL and testbench

Memory-side responder for the single-cycle ARM core's data port: accepts the core's address, write-data and write-strobe, returns read data in the same cycle. Backs a word-addressed data RAM plus a small MMIO page holding a byte output FIFO, with valid/ready drain to an external consumer, and an optional cycle timer. Sits beside the core at top level, wired to its MemWrite/ALUResult/WriteData/ReadData.

---
 rtl/data_mem_pkg.sv | 33 +++
 rtl/data_mem_responder_out_fifo.sv | 67 ++++++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared constants for the data memory responder: MMIO page,
//               register offsets, STATUS bit positions, timer reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

    localparam logic [23:0] c_mmio_page    = 24'hFFFFFF;

    localparam logic [7:0]  c_off_out      = 8'h00;
    localparam logic [7:0]  c_off_status   = 8'h04;
    localparam logic [7:0]  c_off_tcount   = 8'h08;
    localparam logic [7:0]  c_off_tcmp     = 8'h0C;
    localparam logic [7:0]  c_off_tflag    = 8'h10;

    localparam int          c_stat_ovf_bit   = 8;
    localparam int          c_stat_empty_bit = 4;
    localparam int          c_stat_full_bit  = 3;

    localparam logic [31:0] c_tcmp_reset   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_out_fifo.sv
// ============================================================================
// Module      : out_fifo
// Description : Byte FIFO draining MMIO output writes to an external consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int c_aw       = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_wdata,
    input  logic          i_pop,
    output logic [7:0]    o_rdata,
    output logic [c_aw:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf_attempt
);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == (c_aw+1)'(FIFO_DEPTH));
    assign w_pop_ok      = i_pop & ~o_empty;
    // A full FIFO still takes a byte if the head leaves on the same edge.
    assign w_push_ok     = i_push & (~o_full | w_pop_ok);
    assign o_ovf_attempt = i_push & ~w_push_ok;
    assign o_rdata       = r_mem[r_rd_ptr];
    assign o_count       = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (c_aw+1)'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - (c_aw+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Data-port responder: word RAM, MMIO output FIFO, optional
//               cycle timer enabled by macro DATA_MEM_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int c_raw = $clog2(RAM_WORDS);
    localparam int c_cw  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] r_ram [RAM_WORDS];
    logic        r_ovf;

    region_e      w_region;
    logic [7:0]   w_off;
    logic [c_raw-1:0] w_ram_idx;
    logic         w_wr_mmio;
    logic         w_push;
    logic         w_ovf_clr;
    logic         w_ovf_attempt;
    logic         w_full;
    logic         w_empty;
    logic [c_cw-1:0] w_count;
    logic [31:0]  w_count_ext;
    logic [31:0]  w_status;
    logic [31:0]  w_tcount_rd;
    logic [31:0]  w_tcmp_rd;
    logic [31:0]  w_tflag_rd;
    logic         w_unused;

    always_comb begin
        w_region = REGION_NONE;
        if (ALUResult[31:8] == c_mmio_page) begin
            w_region = REGION_MMIO;
        end else if (ALUResult[31:2] < 30'(RAM_WORDS)) begin
            w_region = REGION_RAM;
        end
    end

    assign w_off     = ALUResult[7:0];
    assign w_ram_idx = ALUResult[c_raw+1:2];
    assign w_wr_mmio = MemWrite & (w_region == REGION_MMIO);
    assign w_push    = w_wr_mmio & (w_off == c_off_out);
    assign w_ovf_clr = w_wr_mmio & (w_off == c_off_status) & WriteData[c_stat_ovf_bit];

    // RAM contents survive reset by design.
    always_ff @(posedge CLK) begin
        if (MemWrite && (w_region == REGION_RAM)) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk           (CLK),
        .rst           (reset),
        .i_push        (w_push),
        .i_wdata       (WriteData[7:0]),
        .i_pop         (out_ready),
        .o_rdata       (out_data),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_ovf_attempt (w_ovf_attempt)
    );

    assign out_valid = ~w_empty;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_attempt) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_count_ext = 32'(w_count);
    always_comb begin
        w_status                   = '0;
        w_status[2:0]              = w_count_ext[2:0];
        w_status[c_stat_full_bit]  = w_full;
        w_status[c_stat_empty_bit] = w_empty;
        w_status[c_stat_ovf_bit]   = r_ovf;
    end

`ifdef DATA_MEM_TIMER_EN
    logic [31:0] r_tcount;
    logic [31:0] r_tcmp;
    logic        r_tflag;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tcount <= '0;
            r_tcmp   <= c_tcmp_reset;
            r_tflag  <= 1'b0;
        end else begin
            if (w_wr_mmio && (w_off == c_off_tcount)) begin
                r_tcount <= WriteData;
            end else begin
                r_tcount <= r_tcount + 32'd1;
            end
            if (w_wr_mmio && (w_off == c_off_tcmp)) begin
                r_tcmp <= WriteData;
            end
            // Match on the pre-edge count; a match outranks a software clear.
            if (r_tcount == r_tcmp) begin
                r_tflag <= 1'b1;
            end else if (w_wr_mmio && (w_off == c_off_tflag) && WriteData[0]) begin
                r_tflag <= 1'b0;
            end
        end
    end

    assign w_tcount_rd = r_tcount;
    assign w_tcmp_rd   = r_tcmp;
    assign w_tflag_rd  = {31'b0, r_tflag};
`else
    assign w_tcount_rd = '0;
    assign w_tcmp_rd   = '0;
    assign w_tflag_rd  = '0;
`endif

    always_comb begin
        ReadData = '0;
        case (w_region)
            REGION_RAM: ReadData = r_ram[w_ram_idx];
            REGION_MMIO: begin
                case (w_off)
                    c_off_status: ReadData = w_status;
                    c_off_tcount: ReadData = w_tcount_rd;
                    c_off_tcmp:   ReadData = w_tcmp_rd;
                    c_off_tflag:  ReadData = w_tflag_rd;
                    default:      ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

    assign w_unused = ^{ALUResult[1:0], w_count_ext[31:3]};

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench; FIFO bytes tracked in a queue.
//               Timer checks follow macro DATA_MEM_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    localparam logic [31:0] c_a_out    = 32'hFFFF_FF00;
    localparam logic [31:0] c_a_status = 32'hFFFF_FF04;
    localparam logic [31:0] c_a_tcount = 32'hFFFF_FF08;
    localparam logic [31:0] c_a_tcmp   = 32'hFFFF_FF0C;
    localparam logic [31:0] c_a_tflag  = 32'hFFFF_FF10;

    always #10 CLK = ~CLK;

    data_mem_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ALUResult = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(out_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(out_data), 32'(e));
        end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rd_check("rst_status", c_a_status, 32'h0000_0010);
`ifdef DATA_MEM_TIMER_EN
        rd_check("rst_tcount", c_a_tcount, 32'd0);
        rd_check("rst_tcmp", c_a_tcmp, 32'hFFFF_FFFF);
`else
        rd_check("rst_tcount_off", c_a_tcount, 32'd0);
`endif

        // RAM store/load, byte offset ignored, unmapped region
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_ld", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_ld_off3", 32'h0000_0013, 32'hDEAD_BEEF);
        wr(32'h0000_0000, 32'h1234_5678);
        wr(32'h0000_1000, 32'hCAFE_F00D);
        rd_check("unmapped_ld", 32'h0000_1000, 32'd0);
        rd_check("ram_word0", 32'h0000_0000, 32'h1234_5678);
        rd_check("mmio_other", 32'hFFFF_FF20, 32'd0);

        // Fill past depth with no consumer
        check("pre_push_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wr(c_a_out, 32'h41 + 32'(i));
            if (i < 4) exp_q.push_back(8'(8'h41 + i));
            if (i == 0) begin
                check("push1_valid", 32'(out_valid), 32'd1);
                check("push1_data", 32'(out_data), 32'h41);
            end
        end
        rd_check("full_ovf_status", c_a_status, 32'h0000_010C);
        rd_check("out_reads0", c_a_out, 32'd0);
        check("held_data", 32'(out_data), 32'h41);

        wr(c_a_status, 32'h0000_0100);
        rd_check("ovf_clr_status", c_a_status, 32'h0000_000C);

        // Push into a full FIFO on the same edge as a pop
        ALUResult = c_a_out;
        WriteData = 32'h55;
        MemWrite  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("simul_valid", 32'(out_valid), 32'd1);
        pop_check("simul_pop");
        exp_q.push_back(8'h55);
        tick();
        MemWrite  = 1'b0;
        out_ready = 1'b0;
        rd_check("simul_status", c_a_status, 32'h0000_000C);

        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            if (out_valid) pop_check("drain");
            tick();
        end
        out_ready = 1'b0;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        rd_check("drain_status", c_a_status, 32'h0000_0010);

        // Reset while bytes are pending
        wr(c_a_out, 32'h61);
        wr(c_a_out, 32'h62);
        rd_check("pend_status", c_a_status, 32'h0000_0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_data", 32'(out_data), 32'd0);
        rd_check("rst2_status", c_a_status, 32'h0000_0010);

`ifdef DATA_MEM_TIMER_EN
        begin
            logic seen;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            wr(c_a_tcmp, 32'd5);
            rd_check("tcmp_rb", c_a_tcmp, 32'd5);
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                ALUResult = c_a_tcount;
                #1;
                if (ReadData == 32'd5) begin
                    seen = 1'b1;
                    rd_check("tflag_before", c_a_tflag, 32'd0);
                    tick();
                    rd_check("tflag_after", c_a_tflag, 32'd1);
                    break;
                end
                tick();
            end
            check("tcount_hit5", 32'(seen), 32'd1);
            wr(c_a_tflag, 32'd1);
            rd_check("tflag_clr", c_a_tflag, 32'd0);
            wr(c_a_tcount, 32'hFFFF_FFFF);
            rd_check("tcount_load", c_a_tcount, 32'hFFFF_FFFF);
            tick();
            rd_check("tcount_wrap", c_a_tcount, 32'd0);
        end
`else
        wr(c_a_tcmp, 32'd5);
        rd_check("tcmp_off", c_a_tcmp, 32'd0);
        wr(c_a_tflag, 32'd1);
        rd_check("tflag_off", c_a_tflag, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
